// File: rtl/i2c_slave_byte_fifo.sv
// Byte buffer between an I2C slave byte interface and a uC.
// RX strobe-capture FIFO, TX valid/ready FIFO, sticky error flags.
module i2c_slave_byte_fifo #(
  parameter int RX_DEPTH = 8,
  parameter int TX_DEPTH = 8
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [7:0]                  i2c_rx_data,
  input  logic                        i2c_rx_valid,
  output logic [7:0]                  i2c_tx_data,
  output logic                        i2c_tx_valid,
  input  logic                        i2c_tx_ready,
  output logic [7:0]                  rx_data,
  output logic                        rx_valid,
  input  logic                        rx_ready,
  input  logic [7:0]                  tx_data,
  input  logic                        tx_valid,
  output logic                        tx_ready,
  output logic [$clog2(RX_DEPTH):0]   rx_level,
  output logic [$clog2(TX_DEPTH):0]   tx_level,
  input  logic                        rx_flush,
  input  logic                        tx_flush,
  output logic                        rx_overflow,
  output logic                        tx_underflow,
  input  logic                        clr_flags
);

  localparam int RAW = $clog2(RX_DEPTH);
  localparam int TAW = $clog2(TX_DEPTH);
  localparam logic [RAW:0] RX_ONE = 1;
  localparam logic [TAW:0] TX_ONE = 1;

  logic [7:0]   rx_mem [RX_DEPTH];
  logic [7:0]   tx_mem [TX_DEPTH];

  logic [RAW:0] rx_wr, rx_rd, rx_wr_n, rx_rd_n;
  logic [TAW:0] tx_wr, tx_rd, tx_wr_n, tx_rd_n;

  logic rx_empty, rx_full, rx_push, rx_pop, rx_ovf_set;
  logic tx_empty, tx_full, tx_push, tx_pop, tx_unf_set;

  // RX next-pointer and event decode; flush overrides push/pop
  always_comb begin
    rx_empty   = (rx_wr == rx_rd);
    rx_full    = (rx_wr[RAW-1:0] == rx_rd[RAW-1:0]) &&
                 (rx_wr[RAW] != rx_rd[RAW]);
    rx_pop     = !rx_empty && rx_ready && !rx_flush;
    rx_push    = i2c_rx_valid && !rx_flush &&
                 (!rx_full || rx_pop);
    rx_ovf_set = i2c_rx_valid && !rx_flush &&
                 rx_full && !rx_pop;
    rx_wr_n    = rx_wr;
    rx_rd_n    = rx_rd;
    if (rx_flush) begin
      rx_wr_n = '0;
      rx_rd_n = '0;
    end else begin
      if (rx_push) rx_wr_n = rx_wr + RX_ONE;
      if (rx_pop)  rx_rd_n = rx_rd + RX_ONE;
    end
  end

  // TX next-pointer and event decode; full blocks push even on a pop
  always_comb begin
    tx_empty   = (tx_wr == tx_rd);
    tx_full    = (tx_wr[TAW-1:0] == tx_rd[TAW-1:0]) &&
                 (tx_wr[TAW] != tx_rd[TAW]);
    tx_push    = tx_valid && !tx_full && !tx_flush;
    tx_pop     = i2c_tx_ready && !tx_empty && !tx_flush;
    tx_unf_set = i2c_tx_ready && tx_empty;
    tx_wr_n    = tx_wr;
    tx_rd_n    = tx_rd;
    if (tx_flush) begin
      tx_wr_n = '0;
      tx_rd_n = '0;
    end else begin
      if (tx_push) tx_wr_n = tx_wr + TX_ONE;
      if (tx_pop)  tx_rd_n = tx_rd + TX_ONE;
    end
  end

  // Pointers, registered levels and sticky flags
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_wr        <= '0;
      rx_rd        <= '0;
      tx_wr        <= '0;
      tx_rd        <= '0;
      rx_level     <= '0;
      tx_level     <= '0;
      rx_overflow  <= 1'b0;
      tx_underflow <= 1'b0;
    end else begin
      rx_wr        <= rx_wr_n;
      rx_rd        <= rx_rd_n;
      tx_wr        <= tx_wr_n;
      tx_rd        <= tx_rd_n;
      rx_level     <= rx_wr_n - rx_rd_n;
      tx_level     <= tx_wr_n - tx_rd_n;
      rx_overflow  <= rx_ovf_set | (rx_overflow & ~clr_flags);
      tx_underflow <= tx_unf_set | (tx_underflow & ~clr_flags);
    end
  end

  // Storage writes; contents are don't-care until pointers cover them
  always_ff @(posedge clk) begin
    if (rx_push) rx_mem[rx_wr[RAW-1:0]] <= i2c_rx_data;
    if (tx_push) tx_mem[tx_wr[TAW-1:0]] <= tx_data;
  end

  // Fall-through heads with idle values when empty (FF keeps SDA released)
  always_comb begin
    rx_valid     = !rx_empty;
    rx_data      = rx_empty ? 8'h00 : rx_mem[rx_rd[RAW-1:0]];
    i2c_tx_valid = !tx_empty;
    i2c_tx_data  = tx_empty ? 8'hFF : tx_mem[tx_rd[TAW-1:0]];
    tx_ready     = !tx_full;
  end

endmodule

// File: tb/tb_i2c_slave_byte_fifo.sv
// Scoreboard bench for i2c_slave_byte_fifo.
// Queue-based reference model; monitor checks every cycle.
module tb_i2c_slave_byte_fifo;

  localparam int D = 8;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] i2c_rx_data;
  logic       i2c_rx_valid;
  logic [7:0] i2c_tx_data;
  logic       i2c_tx_valid;
  logic       i2c_tx_ready;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ready;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  logic [3:0] rx_level;
  logic [3:0] tx_level;
  logic       rx_flush;
  logic       tx_flush;
  logic       rx_overflow;
  logic       tx_underflow;
  logic       clr_flags;

  i2c_slave_byte_fifo #(.RX_DEPTH(D), .TX_DEPTH(D)) dut (
    .clk          (clk),
    .rst          (rst),
    .i2c_rx_data  (i2c_rx_data),
    .i2c_rx_valid (i2c_rx_valid),
    .i2c_tx_data  (i2c_tx_data),
    .i2c_tx_valid (i2c_tx_valid),
    .i2c_tx_ready (i2c_tx_ready),
    .rx_data      (rx_data),
    .rx_valid     (rx_valid),
    .rx_ready     (rx_ready),
    .tx_data      (tx_data),
    .tx_valid     (tx_valid),
    .tx_ready     (tx_ready),
    .rx_level     (rx_level),
    .tx_level     (tx_level),
    .rx_flush     (rx_flush),
    .tx_flush     (tx_flush),
    .rx_overflow  (rx_overflow),
    .tx_underflow (tx_underflow),
    .clr_flags    (clr_flags)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       rv;
    logic [7:0] rd;
    logic       tv;
    logic [7:0] td;
    logic       trdy;
    logic [3:0] rl;
    logic [3:0] tl;
    logic       ovf;
    logic       unf;
  } exp_t;

  exp_t     expq[$];
  bit [7:0] rxq[$];
  bit [7:0] txq[$];
  bit       m_ovf;
  bit       m_unf;
  int       checks;
  int       failures;

  task automatic chk(string name, int act, int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h t=%0t",
               name, act, exp, $time);
    end
  endtask

  // Monitor: pops one expectation per cycle and compares
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (expq.size() > 0) begin
        e = expq.pop_front();
        chk("rx_valid", int'(rx_valid), int'(e.rv));
        chk("rx_data", int'(rx_data), int'(e.rd));
        chk("i2c_tx_valid", int'(i2c_tx_valid), int'(e.tv));
        chk("i2c_tx_data", int'(i2c_tx_data), int'(e.td));
        chk("tx_ready", int'(tx_ready), int'(e.trdy));
        chk("rx_level", int'(rx_level), int'(e.rl));
        chk("tx_level", int'(tx_level), int'(e.tl));
        chk("rx_overflow", int'(rx_overflow), int'(e.ovf));
        chk("tx_underflow", int'(tx_underflow), int'(e.unf));
      end
    end
  end

  task automatic idle();
    i2c_rx_valid = 1'b0;
    rx_ready     = 1'b0;
    tx_valid     = 1'b0;
    i2c_tx_ready = 1'b0;
    rx_flush     = 1'b0;
    tx_flush     = 1'b0;
    clr_flags    = 1'b0;
    i2c_rx_data  = 8'($urandom);
    tx_data      = 8'($urandom);
  endtask

  // Predict outputs for this cycle, advance the model, step the clock
  task automatic cycle();
    exp_t e;
    bit   rpop, rfull, ovf_set;
    bit   tpush, tpop, unf_set;
    if (rst) begin
      rxq.delete();
      txq.delete();
      m_ovf = 1'b0;
      m_unf = 1'b0;
    end
    e.rv   = rxq.size() > 0;
    e.rd   = e.rv ? rxq[0] : 8'h00;
    e.tv   = txq.size() > 0;
    e.td   = e.tv ? txq[0] : 8'hFF;
    e.trdy = txq.size() < D;
    e.rl   = 4'(rxq.size());
    e.tl   = 4'(txq.size());
    e.ovf  = m_ovf;
    e.unf  = m_unf;
    expq.push_back(e);
    if (!rst) begin
      ovf_set = 1'b0;
      rfull   = rxq.size() == D;
      rpop    = rxq.size() > 0 && rx_ready;
      if (rx_flush) rxq.delete();
      else begin
        if (rpop) void'(rxq.pop_front());
        if (i2c_rx_valid) begin
          if (!rfull || rpop) rxq.push_back(i2c_rx_data);
          else ovf_set = 1'b1;
        end
      end
      m_ovf   = ovf_set | (m_ovf & !clr_flags);
      tpush   = tx_valid && txq.size() < D;
      tpop    = i2c_tx_ready && txq.size() > 0;
      unf_set = i2c_tx_ready && txq.size() == 0;
      if (tx_flush) txq.delete();
      else begin
        if (tpop) void'(txq.pop_front());
        if (tpush) txq.push_back(tx_data);
      end
      m_unf = unf_set | (m_unf & !clr_flags);
    end
    @(posedge clk);
    #1;
    idle();
  endtask

  task automatic rx_byte(input logic [7:0] b, input logic pop);
    i2c_rx_valid = 1'b1;
    i2c_rx_data  = b;
    rx_ready     = pop;
    cycle();
  endtask

  task automatic tx_byte(input logic [7:0] b);
    tx_valid = 1'b1;
    tx_data  = b;
    cycle();
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    rst      = 1'b1;
    idle();
    @(posedge clk);
    #1;
    // 1: reset and idle
    cycle();
    rst = 1'b0;
    repeat (3) cycle();
    // 2: fill RX, overflow, drain
    for (int i = 0; i < 8; i++) rx_byte(8'h11 + 8'(i), 1'b0);
    rx_byte(8'h99, 1'b0);
    repeat (9) begin rx_ready = 1'b1; cycle(); end
    // 3: full RX with same-cycle push and pop
    clr_flags = 1'b1;
    cycle();
    for (int i = 0; i < 8; i++) rx_byte(8'h31 + 8'(i), 1'b0);
    rx_byte(8'hA5, 1'b1);
    repeat (9) begin rx_ready = 1'b1; cycle(); end
    // 4: TX push three, pop three, then underflow
    for (int i = 0; i < 3; i++) tx_byte(8'hC0 + 8'(i));
    cycle();
    repeat (4) begin
      i2c_tx_ready = 1'b1;
      cycle();
      cycle();
    end
    // 5: TX full, overflow vs clr_flags
    for (int i = 0; i < 8; i++) tx_byte(8'h50 + 8'(i));
    tx_byte(8'hEE);
    tx_valid     = 1'b1;
    tx_data      = 8'hEE;
    i2c_tx_ready = 1'b1;
    cycle();
    for (int i = 0; i < 8; i++) rx_byte(8'h70 + 8'(i), 1'b0);
    clr_flags = 1'b1;
    rx_byte(8'h77, 1'b0);
    cycle();
    clr_flags = 1'b1;
    cycle();
    cycle();
    // 6: flush with concurrent push, then async reset mid-traffic
    rx_flush = 1'b1;
    tx_flush = 1'b1;
    cycle();
    for (int i = 0; i < 3; i++) begin
      tx_valid     = 1'b1;
      tx_data      = 8'h90 + 8'(i);
      rx_byte(8'hA0 + 8'(i), 1'b0);
    end
    rx_flush     = 1'b1;
    tx_flush     = 1'b1;
    i2c_rx_valid = 1'b1;
    tx_valid     = 1'b1;
    cycle();
    cycle();
    for (int i = 0; i < 4; i++) begin
      tx_valid = 1'b1;
      rx_byte(8'(i), 1'b0);
    end
    #2;
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    cycle();
    // Randomized traffic
    for (int n = 0; n < 3000; n++) begin
      i2c_rx_valid = $urandom_range(0, 1) == 1;
      rx_ready     = $urandom_range(0, 9) < 4;
      tx_valid     = $urandom_range(0, 1) == 1;
      i2c_tx_ready = $urandom_range(0, 9) < 4;
      rx_flush     = $urandom_range(0, 99) < 2;
      tx_flush     = $urandom_range(0, 99) < 2;
      clr_flags    = $urandom_range(0, 99) < 3;
      if ($urandom_range(0, 999) < 2) rst = 1'b1;
      cycle();
      rst = 1'b0;
    end
    @(negedge clk);
    #1;
    if (expq.size() != 0) begin
      failures++;
      $display("FAIL drain pending=%0d expected=0", expq.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
